// File: rtl/frame_write_sequencer.sv
// frame_write_sequencer: accepts frame-write commands over a valid/ready
// handshake and drives one tile column's shared FrameData bus plus one-hot
// FrameStrobe lines with programmable setup / strobe / hold timing.
//
// Handshake: a command transfers on the rising CLK edge where s_valid and
// s_ready are both high; s_ready is high only in IDLE. s_frame_addr and
// s_frame_data are sampled on that edge only. Out-of-range addresses are
// accepted and dropped (sticky err_addr set).
module frame_write_sequencer #(
    parameter int MaxFramesPerCol = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int FrameAddrWidth  = 5,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FrameAddrWidth-1:0]  s_frame_addr,
    input  logic [FrameBitsPerRow-1:0] s_frame_data,
    input  logic                       clear_err,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err_addr,
    output logic [15:0]                frames_written,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int CntW = 16;
    // Last cycle index of each timed phase; a phase with 0 cycles is never entered.
    localparam logic [CntW-1:0] SETUP_LAST  = CntW'(SetupCycles - 1);
    localparam logic [CntW-1:0] STROBE_LAST = CntW'(StrobeCycles - 1);
    localparam logic [CntW-1:0] HOLD_LAST   = CntW'(HoldCycles - 1);
    localparam logic [FrameAddrWidth:0] ADDR_LIMIT = (FrameAddrWidth + 1)'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

    state_t                       state_q, state_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [FrameAddrWidth-1:0]    addr_q, addr_d;
    logic [FrameBitsPerRow-1:0]   frame_data_q, frame_data_d;
    logic                         err_q, err_d;
    logic [15:0]                  frames_written_q, frames_written_d;

    logic accept;
    logic addr_ok;
    logic strobe_done;

    assign accept      = s_valid && (state_q == ST_IDLE);
    assign addr_ok     = ({1'b0, s_frame_addr} < ADDR_LIMIT);
    assign strobe_done = (state_q == ST_STROBE) && (cnt_q == STROBE_LAST);

    // State register: async reset returns to IDLE, which drops FrameStrobe at once.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: each timed phase counts cnt_q from 0 to its last index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept && addr_ok) begin
                    state_d = (SetupCycles > 0) ? ST_SETUP : ST_STROBE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = (HoldCycles > 0) ? ST_HOLD : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath next values: frame word/address capture, sticky error, strobe counter.
    always_comb begin
        frame_data_d     = frame_data_q;
        addr_d           = addr_q;
        err_d            = err_q;
        frames_written_d = frames_written_q;
        if (accept && addr_ok) begin
            frame_data_d = s_frame_data;
            addr_d       = s_frame_addr;
        end
        // An error on the same edge as clear_err wins over the clear.
        if (accept && !addr_ok) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
        if (strobe_done) begin
            frames_written_d = frames_written_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frame_data_q     <= '0;
            addr_q           <= '0;
            err_q            <= 1'b0;
            frames_written_q <= '0;
        end else begin
            frame_data_q     <= frame_data_d;
            addr_q           <= addr_d;
            err_q            <= err_d;
            frames_written_q <= frames_written_d;
        end
    end

    // Outputs decoded from registered state only; no path from the s_* inputs.
    always_comb begin
        s_ready     = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        FrameStrobe = '0;
        if (state_q == ST_STROBE) begin
            FrameStrobe = STROBE_ONE << addr_q;
        end
    end

    assign FrameData      = frame_data_q;
    assign err_addr       = err_q;
    assign frames_written = frames_written_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Self-checking bench for frame_write_sequencer. Three instances:
//   dut_a: defaults (32 frames, setup 1 / strobe 1 / hold 1)
//   dut_b: 32 frames, setup 0 / strobe 3 / hold 0
//   dut_c: 20 frames, defaults otherwise (address range errors)
// The reference model is a per-command timeline: after the accept edge m=0,
// the strobe is active for edges S..S+T-1, the count bumps at edge S+T and
// the controller is ready again at edge S+T+H.
module tb_frame_write_sequencer;

  logic CLK;
  int tests = 0;
  int fails = 0;

  // dut_a (index 0) and dut_b (index 1) signals
  logic        rst_n   [2];
  logic        s_valid [2];
  logic [4:0]  s_addr  [2];
  logic [31:0] s_data  [2];
  logic        s_ready [2];
  logic [31:0] fdata   [2];
  logic [31:0] fstrobe [2];
  logic        busy    [2];
  logic        err     [2];
  logic [15:0] fw      [2];
  logic [1:0]  dbg     [2];

  logic [31:0] exp_data  [2];
  logic [15:0] exp_count [2];

  // dut_c signals
  logic        c_rst_n, c_valid, c_clr, c_ready, c_busy, c_err;
  logic [4:0]  c_addr;
  logic [31:0] c_data, c_fdata;
  logic [19:0] c_strobe;
  logic [15:0] c_fw;
  logic [1:0]  c_dbg;
  logic [31:0] exp_c_data;
  logic [15:0] exp_c_count;
  logic        exp_c_err;

  frame_write_sequencer dut_a (
    .CLK(CLK), .resetn(rst_n[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_frame_addr(s_addr[0]), .s_frame_data(s_data[0]), .clear_err(1'b0),
    .FrameData(fdata[0]), .FrameStrobe(fstrobe[0]), .busy(busy[0]),
    .err_addr(err[0]), .frames_written(fw[0]), .dbg_state(dbg[0])
  );

  frame_write_sequencer #(.SetupCycles(0), .StrobeCycles(3), .HoldCycles(0)) dut_b (
    .CLK(CLK), .resetn(rst_n[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_frame_addr(s_addr[1]), .s_frame_data(s_data[1]), .clear_err(1'b0),
    .FrameData(fdata[1]), .FrameStrobe(fstrobe[1]), .busy(busy[1]),
    .err_addr(err[1]), .frames_written(fw[1]), .dbg_state(dbg[1])
  );

  frame_write_sequencer #(.MaxFramesPerCol(20)) dut_c (
    .CLK(CLK), .resetn(c_rst_n), .s_valid(c_valid), .s_ready(c_ready),
    .s_frame_addr(c_addr), .s_frame_data(c_data), .clear_err(c_clr),
    .FrameData(c_fdata), .FrameStrobe(c_strobe), .busy(c_busy),
    .err_addr(c_err), .frames_written(c_fw), .dbg_state(c_dbg)
  );

  // Clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int p_s(input int d); return (d == 0) ? 1 : 0; endfunction
  function automatic int p_t(input int d); return (d == 0) ? 1 : 3; endfunction
  function automatic int p_h(input int d); return (d == 0) ? 1 : 0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command to dut_a/dut_b, checked every cycle until ready returns.
  // Called at a negedge; returns at the negedge where ready is back.
  task automatic run_cmd(input int d, input logic [4:0] addr, input logic [31:0] data,
                         input bit keep_valid);
    int waits;
    int s, t, l;
    logic [31:0] exp_strobe;
    s = p_s(d);
    t = p_t(d);
    l = s + t + p_h(d);
    chk("pre_accept_data", fdata[d], exp_data[d]);
    s_addr[d]  = addr;
    s_data[d]  = data;
    s_valid[d] = 1'b1;
    waits = 0;
    while (s_ready[d] !== 1'b1 && waits < 64) begin
      @(negedge CLK);
      waits++;
    end
    chk("accept_wait", 32'(waits < 64), 32'd1);
    @(posedge CLK);
    exp_data[d] = data;
    for (int m = 0; m <= l; m++) begin
      @(negedge CLK);
      if (m == 0 && !keep_valid) s_valid[d] = 1'b0;
      if (m == s + t) exp_count[d] = exp_count[d] + 16'd1;
      exp_strobe = (m >= s && m < s + t) ? (32'd1 << addr) : 32'd0;
      chk("strobe",         fstrobe[d],       exp_strobe);
      chk("frame_data",     fdata[d],         exp_data[d]);
      chk("ready",          32'(s_ready[d]),  32'(m == l));
      chk("busy",           32'(busy[d]),     32'(m != l));
      chk("frames_written", 32'(fw[d]),       32'(exp_count[d]));
    end
    chk("err_addr_clean", 32'(err[d]), 32'd0);
  endtask

  // One command to dut_c with optional clear_err on the accept edge.
  task automatic c_cmd(input logic [4:0] addr, input logic [31:0] data, input logic clr);
    bit ok;
    logic [19:0] exp_strobe;
    chk("c_ready_before", 32'(c_ready), 32'd1);
    c_addr  = addr;
    c_data  = data;
    c_valid = 1'b1;
    c_clr   = clr;
    @(posedge CLK);
    ok = (addr < 5'd20);
    if (ok) exp_c_data = data;
    exp_c_err = ok ? (exp_c_err & ~clr) : 1'b1;
    for (int m = 0; m <= 3; m++) begin
      @(negedge CLK);
      if (m == 0) begin
        c_valid = 1'b0;
        c_clr   = 1'b0;
      end
      if (ok && m == 2) exp_c_count = exp_c_count + 16'd1;
      exp_strobe = (ok && m == 1) ? (20'd1 << addr) : 20'd0;
      chk("c_strobe",         32'(c_strobe), 32'(exp_strobe));
      chk("c_frame_data",     c_fdata,       exp_c_data);
      chk("c_err_addr",       32'(c_err),    32'(exp_c_err));
      chk("c_ready",          32'(c_ready),  ok ? 32'(m == 3) : 32'd1);
      chk("c_frames_written", 32'(c_fw),     32'(exp_c_count));
    end
  endtask

  initial begin
    logic [31:0] r;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; s_valid[d] = 1'b0; s_addr[d] = '0; s_data[d] = '0;
      exp_data[d] = '0; exp_count[d] = '0;
    end
    c_rst_n = 1'b0; c_valid = 1'b0; c_clr = 1'b0; c_addr = '0; c_data = '0;
    exp_c_data = '0; exp_c_count = '0; exp_c_err = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",   32'(s_ready[d]), 32'd1);
      chk("rst_busy",    32'(busy[d]),    32'd0);
      chk("rst_strobe",  fstrobe[d],      32'd0);
      chk("rst_data",    fdata[d],        32'd0);
      chk("rst_err",     32'(err[d]),     32'd0);
      chk("rst_count",   32'(fw[d]),      32'd0);
    end
    chk("c_rst_err", 32'(c_err), 32'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1; c_rst_n = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", 32'(s_ready[0]), 32'd1);

    // Default timing: addr 3, 0xDEADBEEF
    run_cmd(0, 5'd3, 32'hDEADBEEF, 1'b0);
    chk("first_count", 32'(fw[0]), 32'd1);

    // Continuous s_valid on dut_b, addr 31, data 1,2,3
    run_cmd(1, 5'd31, 32'd1, 1'b1);
    run_cmd(1, 5'd31, 32'd2, 1'b1);
    run_cmd(1, 5'd31, 32'd3, 1'b0);
    chk("burst_count", 32'(fw[1]), 32'd3);

    // Address range errors on the 20-frame column
    c_cmd(5'd3,  $urandom, 1'b0);
    c_cmd(5'd31, $urandom, 1'b0);
    c_cmd(5'd20, $urandom, 1'b0);
    c_cmd(5'd19, $urandom, 1'b0);
    c_clr = 1'b1;
    @(posedge CLK);
    exp_c_err = 1'b0;
    @(negedge CLK);
    c_clr = 1'b0;
    chk("c_clear_err", 32'(c_err), 32'(exp_c_err));
    c_cmd(5'd31, $urandom, 1'b1);
    c_cmd(5'd7,  $urandom, 1'b1);

    // Async reset during the strobe of an addr 5 write on dut_a
    s_addr[0] = 5'd5; s_data[0] = $urandom; s_valid[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    s_valid[0] = 1'b0;
    @(negedge CLK);
    chk("mid_strobe", fstrobe[0], 32'h0000_0020);
    #2 rst_n[0] = 1'b0;
    #1;
    exp_data[0] = '0; exp_count[0] = '0;
    chk("arst_strobe", fstrobe[0],      32'd0);
    chk("arst_data",   fdata[0],        32'd0);
    chk("arst_count",  32'(fw[0]),      32'd0);
    chk("arst_ready",  32'(s_ready[0]), 32'd1);
    @(negedge CLK);
    rst_n[0] = 1'b1;
    @(negedge CLK);
    chk("arst_release_ready",  32'(s_ready[0]), 32'd1);
    chk("arst_release_strobe", fstrobe[0],      32'd0);

    // Randomised command stream on both 32-frame instances
    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      r = $urandom;
      run_cmd(d, 5'($urandom_range(0, 31)), r, 1'b0);
    end

    // Counter wrap: preload 0xFFFF, then one more write
    force dut_b.frames_written_q = 16'hFFFF;
    @(negedge CLK);
    release dut_b.frames_written_q;
    exp_count[1] = 16'hFFFF;
    @(negedge CLK);
    chk("preload_count", 32'(fw[1]), 32'(exp_count[1]));
    run_cmd(1, 5'd0, 32'hA5A5_5A5A, 1'b0);
    chk("wrap_count", 32'(fw[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
